// File: rtl/me_stage_hs.sv
// Memory-access stage between EX and WB: waits for a variable-latency data_ok
// response, extracts/extends sub-word load data, and drops stale responses after a flush.
module me_stage_hs #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_to_me_valid,
    output logic              me_allow_in,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_res_from_mem,
    input  logic              ex_mem_req,
    input  logic              ex_gr_we,
    input  logic [DEST_W-1:0] ex_dest,
    input  logic [1:0]        ex_ld_size,
    input  logic              ex_ld_sign,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    input  logic              wb_allow_in,
    output logic              me_to_wb_valid,
    output logic [PC_W-1:0]   me_pc,
    output logic              me_gr_we,
    output logic [DEST_W-1:0] me_dest,
    output logic [DATA_W-1:0] me_final_result,
    output logic [DEST_W-1:0] me_fwd_dest,
    output logic [DATA_W-1:0] me_fwd_data,
    output logic              me_fwd_stall,
    output logic              me_mem_busy,
    output logic [1:0]        me_state
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                discard_q, discard_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                res_mem_q, res_mem_d;
    logic                gr_we_q, gr_we_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [1:0]          ld_size_q, ld_size_d;
    logic                ld_sign_q, ld_sign_d;

    logic                valid;
    logic                dok_live;
    logic                ready_go;
    logic                entry;
    logic [DATA_W-1:0]   ld_src;
    logic [OFF_W-1:0]    ld_off;
    logic [DATA_W-1:0]   ld_shifted;
    logic [DATA_W-1:0]   ld_top;
    logic [DATA_W-1:0]   ld_ext;
    int                  ld_sh;

    // Handshake: an instruction moves EX->ME when ex_to_me_valid && me_allow_in,
    // and ME->WB when me_to_wb_valid && wb_allow_in; neither side retracts valid.
    assign valid       = (state_q != ST_EMPTY);
    assign dok_live    = data_sram_data_ok && !discard_q;
    assign ready_go    = (state_q == ST_READY) || ((state_q == ST_WAIT) && dok_live);
    assign me_allow_in = !valid || (ready_go && wb_allow_in);
    assign entry       = ex_to_me_valid && me_allow_in;

    // Byte lane selection; the response is used directly in the cycle it arrives.
    always_comb begin
        ld_src = (state_q == ST_WAIT) ? data_sram_rdata : rdata_q;
        ld_off = alu_q[OFF_W-1:0];
        ld_sh  = DATA_W - 8;
        case (ld_size_q)
            2'd0: ld_sh = DATA_W - 8;
            2'd1: begin
                ld_off[0] = 1'b0;
                ld_sh     = DATA_W - 16;
            end
            2'd2: begin
                ld_off[1:0] = 2'b00;
                ld_sh       = DATA_W - 32;
            end
            default: begin
                ld_off = '0;
                ld_sh  = 0;
            end
        endcase
        ld_shifted = ld_src >> {ld_off, 3'b000};
        ld_top     = ld_shifted << ld_sh;
        ld_ext     = ld_sign_q ? DATA_W'($signed(ld_top) >>> ld_sh) : (ld_top >> ld_sh);
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        rdata_d   = rdata_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        res_mem_d = res_mem_q;
        gr_we_d   = gr_we_q;
        dest_d    = dest_q;
        ld_size_d = ld_size_q;
        ld_sign_d = ld_sign_q;

        if (data_sram_data_ok && discard_q) begin
            discard_d = 1'b0;
        end
        // A flushed request still owes one response unless it arrives right now.
        if (flush && (state_q == ST_WAIT) && !dok_live) begin
            discard_d = 1'b1;
        end

        if ((state_q == ST_WAIT) && dok_live) begin
            rdata_d = data_sram_rdata;
        end

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (entry) begin
            state_d = ex_mem_req ? ST_WAIT : ST_READY;
        end else if (valid && ready_go && wb_allow_in) begin
            state_d = ST_EMPTY;
        end else if ((state_q == ST_WAIT) && dok_live) begin
            state_d = ST_READY;
        end

        if (entry) begin
            pc_d      = ex_pc;
            alu_d     = ex_alu_result;
            res_mem_d = ex_res_from_mem;
            gr_we_d   = ex_gr_we;
            dest_d    = ex_dest;
            ld_size_d = ex_ld_size;
            ld_sign_d = ex_ld_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            discard_q <= 1'b0;
            rdata_q   <= '0;
            pc_q      <= '0;
            alu_q     <= '0;
            res_mem_q <= 1'b0;
            gr_we_q   <= 1'b0;
            dest_q    <= '0;
            ld_size_q <= 2'd0;
            ld_sign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            rdata_q   <= rdata_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            res_mem_q <= res_mem_d;
            gr_we_q   <= gr_we_d;
            dest_q    <= dest_d;
            ld_size_q <= ld_size_d;
            ld_sign_q <= ld_sign_d;
        end
    end

    assign me_to_wb_valid  = valid && ready_go && !flush;
    assign me_pc           = pc_q;
    assign me_gr_we        = valid && gr_we_q;
    assign me_dest         = dest_q;
    assign me_final_result = res_mem_q ? ld_ext : alu_q;
    assign me_fwd_dest     = (valid && gr_we_q) ? dest_q : '0;
    assign me_fwd_data     = me_final_result;
    assign me_fwd_stall    = valid && res_mem_q && !ready_go;
    assign me_mem_busy     = (valid && (state_q == ST_WAIT)) || discard_q;
    assign me_state        = state_q;

endmodule

// File: tb/tb_me_stage_hs.sv
// Directed bench for me_stage_hs: a 32-bit instance for the main sequence and a
// 64-bit instance for wide sub-word extraction.
module tb_me_stage_hs;

    logic        clk;
    logic        resetn;

    logic        ex_to_me_valid, me_allow_in;
    logic [31:0] ex_pc, ex_alu_result;
    logic        ex_res_from_mem, ex_mem_req, ex_gr_we;
    logic [4:0]  ex_dest;
    logic [1:0]  ex_ld_size;
    logic        ex_ld_sign;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush, wb_allow_in;
    logic        me_to_wb_valid, me_gr_we;
    logic [31:0] me_pc, me_final_result, me_fwd_data;
    logic [4:0]  me_dest, me_fwd_dest;
    logic        me_fwd_stall, me_mem_busy;
    logic [1:0]  me_state;

    logic        w_ex_valid, w_allow_in;
    logic [31:0] w_ex_pc, w_pc;
    logic [63:0] w_ex_alu, w_rdata, w_final, w_fwd_data;
    logic        w_ex_res_mem, w_ex_mem_req, w_ex_gr_we, w_ex_sign;
    logic [4:0]  w_ex_dest, w_dest, w_fwd_dest;
    logic [1:0]  w_ex_size, w_state;
    logic        w_data_ok, w_flush, w_wb_allow;
    logic        w_to_wb_valid, w_gr_we, w_fwd_stall, w_busy;

    int n_vec;
    int n_err;

    me_stage_hs #(.DATA_W(32), .PC_W(32), .DEST_W(5)) dut (
        .clk(clk), .resetn(resetn),
        .ex_to_me_valid(ex_to_me_valid), .me_allow_in(me_allow_in),
        .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_res_from_mem(ex_res_from_mem), .ex_mem_req(ex_mem_req),
        .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
        .ex_ld_size(ex_ld_size), .ex_ld_sign(ex_ld_sign),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .wb_allow_in(wb_allow_in),
        .me_to_wb_valid(me_to_wb_valid), .me_pc(me_pc), .me_gr_we(me_gr_we),
        .me_dest(me_dest), .me_final_result(me_final_result),
        .me_fwd_dest(me_fwd_dest), .me_fwd_data(me_fwd_data),
        .me_fwd_stall(me_fwd_stall), .me_mem_busy(me_mem_busy),
        .me_state(me_state)
    );

    me_stage_hs #(.DATA_W(64), .PC_W(32), .DEST_W(5)) dut64 (
        .clk(clk), .resetn(resetn),
        .ex_to_me_valid(w_ex_valid), .me_allow_in(w_allow_in),
        .ex_pc(w_ex_pc), .ex_alu_result(w_ex_alu),
        .ex_res_from_mem(w_ex_res_mem), .ex_mem_req(w_ex_mem_req),
        .ex_gr_we(w_ex_gr_we), .ex_dest(w_ex_dest),
        .ex_ld_size(w_ex_size), .ex_ld_sign(w_ex_sign),
        .data_sram_data_ok(w_data_ok), .data_sram_rdata(w_rdata),
        .flush(w_flush), .wb_allow_in(w_wb_allow),
        .me_to_wb_valid(w_to_wb_valid), .me_pc(w_pc), .me_gr_we(w_gr_we),
        .me_dest(w_dest), .me_final_result(w_final),
        .me_fwd_dest(w_fwd_dest), .me_fwd_data(w_fwd_data),
        .me_fwd_stall(w_fwd_stall), .me_mem_busy(w_busy),
        .me_state(w_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] alu, input logic from_mem, input logic req,
                         input logic gr_we, input logic [4:0] dest,
                         input logic [1:0] size, input logic sign);
        ex_to_me_valid  = 1'b1;
        ex_pc           = ex_pc + 32'd4;
        ex_alu_result   = alu;
        ex_res_from_mem = from_mem;
        ex_mem_req      = req;
        ex_gr_we        = gr_we;
        ex_dest         = dest;
        ex_ld_size      = size;
        ex_ld_sign      = sign;
        tick();
        ex_to_me_valid  = 1'b0;
    endtask

    // Load whose response arrives in the first WAIT cycle with WB ready.
    task automatic load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [31:0] rdata, input logic [31:0] exp);
        issue(addr, 1'b1, 1'b1, 1'b1, 5'd3, size, sign);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        chk({tag, "_valid"}, 64'(me_to_wb_valid), 64'd1);
        chk(tag, 64'(me_final_result), 64'(exp));
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic load64(input string tag, input logic [63:0] addr, input logic [1:0] size,
                          input logic sign, input logic [63:0] rdata, input logic [63:0] exp);
        w_ex_valid   = 1'b1;
        w_ex_pc      = 32'h8000;
        w_ex_alu     = addr;
        w_ex_res_mem = 1'b1;
        w_ex_mem_req = 1'b1;
        w_ex_gr_we   = 1'b1;
        w_ex_dest    = 5'd4;
        w_ex_size    = size;
        w_ex_sign    = sign;
        tick();
        w_ex_valid   = 1'b0;
        w_data_ok    = 1'b1;
        w_rdata      = rdata;
        #1;
        chk({tag, "_valid"}, 64'(w_to_wb_valid), 64'd1);
        chk(tag, w_final, exp);
        tick();
        w_data_ok    = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        ex_to_me_valid = 1'b0; ex_pc = 32'h1000; ex_alu_result = '0;
        ex_res_from_mem = 1'b0; ex_mem_req = 1'b0; ex_gr_we = 1'b0; ex_dest = '0;
        ex_ld_size = 2'd0; ex_ld_sign = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        flush = 1'b0; wb_allow_in = 1'b1;
        w_ex_valid = 1'b0; w_ex_pc = '0; w_ex_alu = '0; w_ex_res_mem = 1'b0;
        w_ex_mem_req = 1'b0; w_ex_gr_we = 1'b0; w_ex_dest = '0; w_ex_size = 2'd0;
        w_ex_sign = 1'b0; w_data_ok = 1'b0; w_rdata = '0; w_flush = 1'b0; w_wb_allow = 1'b1;

        tick();
        tick();
        #1;
        chk("rst_valid", 64'(me_to_wb_valid), 64'd0);
        chk("rst_allow", 64'(me_allow_in), 64'd1);
        chk("rst_busy", 64'(me_mem_busy), 64'd0);
        chk("rst_fwd_dest", 64'(me_fwd_dest), 64'd0);
        chk("rst_stall", 64'(me_fwd_stall), 64'd0);
        chk("rst_gr_we", 64'(me_gr_we), 64'd0);
        resetn = 1'b1;
        tick();

        // ALU op: result one cycle after entry
        issue(32'h1234, 1'b0, 1'b0, 1'b1, 5'd5, 2'd2, 1'b0);
        #1;
        chk("alu_valid", 64'(me_to_wb_valid), 64'd1);
        chk("alu_result", 64'(me_final_result), 64'h1234);
        chk("alu_fwd_dest", 64'(me_fwd_dest), 64'd5);
        chk("alu_fwd_data", 64'(me_fwd_data), 64'h1234);
        chk("alu_pc", 64'(me_pc), 64'h1004);
        chk("alu_gr_we", 64'(me_gr_we), 64'd1);
        tick();
        chk("alu_retired", 64'(me_to_wb_valid), 64'd0);

        // ALU op without GPR write hides the forwarding dest
        issue(32'h77, 1'b0, 1'b0, 1'b0, 5'd6, 2'd2, 1'b0);
        #1;
        chk("nowe_fwd_dest", 64'(me_fwd_dest), 64'd0);
        tick();

        // ld.w with three waiting cycles
        issue(32'h100, 1'b1, 1'b1, 1'b1, 5'd7, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldw_stall", 64'(me_fwd_stall), 64'd1);
            chk("ldw_wait_valid", 64'(me_to_wb_valid), 64'd0);
            chk("ldw_busy", 64'(me_mem_busy), 64'd1);
            chk("ldw_wait_state", 64'(me_state), 64'd1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        #1;
        chk("ldw_valid", 64'(me_to_wb_valid), 64'd1);
        chk("ldw_result", 64'(me_final_result), 64'hDEADBEEF);
        chk("ldw_fwd_data", 64'(me_fwd_data), 64'hDEADBEEF);
        chk("ldw_stall_off", 64'(me_fwd_stall), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldw_done_valid", 64'(me_to_wb_valid), 64'd0);
        chk("ldw_done_busy", 64'(me_mem_busy), 64'd0);

        // Sub-word extraction
        load32("ldb_off3", 32'h203, 2'd0, 1'b1, 32'h80112233, 32'hFFFFFF80);
        load32("ldbu_off3", 32'h203, 2'd0, 1'b0, 32'h80112233, 32'h00000080);
        load32("ldh_off2", 32'h202, 2'd1, 1'b1, 32'h80112233, 32'hFFFF8011);
        load32("ldh_off3_align", 32'h203, 2'd1, 1'b1, 32'h80112233, 32'hFFFF8011);
        load32("ldhu_off0", 32'h200, 2'd1, 1'b0, 32'h80112233, 32'h00002233);
        load32("ldb_off1", 32'h201, 2'd0, 1'b1, 32'h80112233, 32'h00000022);
        load32("ldw_off2_align", 32'h202, 2'd2, 1'b1, 32'h80112233, 32'h80112233);

        // Store: response consumed, ALU value written back, no forward stall
        issue(32'h500, 1'b0, 1'b1, 1'b0, 5'd0, 2'd2, 1'b0);
        #1;
        chk("st_busy", 64'(me_mem_busy), 64'd1);
        chk("st_stall", 64'(me_fwd_stall), 64'd0);
        chk("st_wait_valid", 64'(me_to_wb_valid), 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000FFFF;
        #1;
        chk("st_valid", 64'(me_to_wb_valid), 64'd1);
        chk("st_result", 64'(me_final_result), 64'h500);
        tick();
        data_sram_data_ok = 1'b0;

        // WB stall on the response cycle: buffered and held in READY
        issue(32'h300, 1'b1, 1'b1, 1'b1, 5'd8, 2'd2, 1'b0);
        wb_allow_in       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55;
        #1;
        chk("hold_dok_allow", 64'(me_allow_in), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_state", 64'(me_state), 64'd2);
            chk("hold_result", 64'(me_final_result), 64'h55);
            chk("hold_valid", 64'(me_to_wb_valid), 64'd1);
            chk("hold_allow", 64'(me_allow_in), 64'd0);
            chk("hold_busy", 64'(me_mem_busy), 64'd0);
            tick();
        end
        wb_allow_in = 1'b1;
        #1;
        chk("hold_release_allow", 64'(me_allow_in), 64'd1);
        chk("hold_release_result", 64'(me_final_result), 64'h55);
        tick();
        #1;
        chk("hold_empty_state", 64'(me_state), 64'd0);

        // Flush in WAIT; stale 0xAA dropped while the next load waits for 0xBB
        issue(32'h400, 1'b1, 1'b1, 1'b1, 5'd9, 2'd2, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_valid", 64'(me_to_wb_valid), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_discard_busy", 64'(me_mem_busy), 64'd1);
        chk("fl_fwd_dest", 64'(me_fwd_dest), 64'd0);
        chk("fl_allow", 64'(me_allow_in), 64'd1);
        issue(32'h404, 1'b1, 1'b1, 1'b1, 5'd10, 2'd2, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAA;
        #1;
        chk("fl_stale_valid", 64'(me_to_wb_valid), 64'd0);
        chk("fl_stale_stall", 64'(me_fwd_stall), 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl_new_waiting", 64'(me_state), 64'd1);
        chk("fl_new_valid", 64'(me_to_wb_valid), 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBB;
        #1;
        chk("fl_bb_valid", 64'(me_to_wb_valid), 64'd1);
        chk("fl_bb_result", 64'(me_final_result), 64'hBB);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl_bb_busy", 64'(me_mem_busy), 64'd0);

        // Flush coinciding with data_ok: nothing left to discard
        issue(32'h408, 1'b1, 1'b1, 1'b1, 5'd11, 2'd2, 1'b0);
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCC;
        #1;
        chk("flok_valid", 64'(me_to_wb_valid), 64'd0);
        tick();
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("flok_busy", 64'(me_mem_busy), 64'd0);

        // Reset with discard pending
        issue(32'h40C, 1'b1, 1'b1, 1'b1, 5'd12, 2'd2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("rstw_pre_busy", 64'(me_mem_busy), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("rstw_busy", 64'(me_mem_busy), 64'd0);
        chk("rstw_allow", 64'(me_allow_in), 64'd1);
        chk("rstw_valid", 64'(me_to_wb_valid), 64'd0);
        chk("rstw_state", 64'(me_state), 64'd0);

        // 64-bit datapath
        load64("w_ldw_off4_s", 64'h1004, 2'd2, 1'b1, 64'h87654321_12345678, 64'hFFFFFFFF_87654321);
        load64("w_ldwu_off4", 64'h1004, 2'd2, 1'b0, 64'h87654321_12345678, 64'h00000000_87654321);
        load64("w_ldd", 64'h1000, 2'd3, 1'b1, 64'h87654321_12345678, 64'h87654321_12345678);
        load64("w_ldb_off7", 64'h1007, 2'd0, 1'b1, 64'h87654321_12345678, 64'hFFFFFFFF_FFFFFF87);
        load64("w_ldh_off6", 64'h1006, 2'd1, 1'b0, 64'h87654321_12345678, 64'h00000000_00008765);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/me_stage_hs.md
Name: me_stage_hs

Overview:
Memory-access stage of the in-order LoongArch pipeline, sitting between EX and WB. It is the successor to the fixed-latency memory stage. It accepts a load/store response over a request/response (data_ok) SRAM-like interface with arbitrary latency, and extracts and extends sub-word load data for any DATA_W. It buffers the response when WB stalls, supports pipeline flush with stale-response discard, and exposes forwarding and a load-use stall hint.

Parameters:
DATA_W, 32, datapath/bus width; 32 or 64
PC_W, 32, program-counter width
DEST_W, 5, register-index width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ex_to_me_valid  in  1  EX holds a valid instruction
me_allow_in  out  1  ME can accept from EX this cycle
ex_pc  in  PC_W  instruction PC
ex_alu_result  in  DATA_W  ALU result / memory address
ex_res_from_mem  in  1  instruction is a load
ex_mem_req  in  1  EX issued an accepted memory request (load or store) for this instruction
ex_gr_we  in  1  writes a GPR
ex_dest  in  DEST_W  destination register
ex_ld_size  in  2  0 byte, 1 half, 2 word, 3 dword (3 legal only when DATA_W=64)
ex_ld_sign  in  1  1 sign-extend, 0 zero-extend
data_sram_data_ok  in  1  memory response valid (one pulse per accepted request, in order)
data_sram_rdata  in  DATA_W  response data
flush  in  1  cancel instruction in ME (exception/ertn)
wb_allow_in  in  1  WB can accept
me_to_wb_valid  out  1  result valid toward WB
me_pc  out  PC_W  PC toward WB
me_gr_we  out  1  GPR write enable toward WB
me_dest  out  DEST_W  destination toward WB
me_final_result  out  DATA_W  writeback data
me_fwd_dest  out  DEST_W  forwarding dest; 0 when invalid or not gr_we
me_fwd_data  out  DATA_W  forwarding data
me_fwd_stall  out  1  load in ME whose data is not yet available
me_mem_busy  out  1  response outstanding or discard pending; EX must not issue while 1

Behaviour:
- Internal state: valid; latched EX fields; FSM {EMPTY, WAIT, READY}; rdata buffer; discard flag.
- Reset (resetn=0 at posedge): valid=0, FSM=EMPTY, discard=0. All valid/enable outputs are 0; data outputs are don't-care.
- Entry: when ex_to_me_valid && me_allow_in, latch all fields. Next state is WAIT if ex_mem_req, otherwise READY.
  - Store: the response is consumed without using its data.
  - ALU op: READY next cycle (1-cycle latency, same as before).
- me_allow_in = !valid || (ready_go && wb_allow_in).
- ready_go = (state==READY) || (state==WAIT && data_sram_data_ok && !discard).
- me_to_wb_valid = valid && ready_go && !flush.
- WAIT:
  - On a data_ok that is not consumed by discard, capture rdata into the buffer.
  - If wb_allow_in the same cycle, the result passes through combinationally and the instruction retires; otherwise go to READY and hold the buffer.
  - WB stall in READY holds all outputs stable.
- Load extraction: offset = alu_result[log2(DATA_W/8)-1:0], aligned to size. Lane = rdata >> (offset*8), truncated to 8/16/32/64 bits, then sign- or zero-extended to DATA_W. Result is rdata directly when size equals DATA_W.
- me_final_result = res_from_mem ? extracted : alu_result.
- Forwarding:
  - me_fwd_dest = dest masked by valid && gr_we.
  - me_fwd_data = me_final_result.
  - me_fwd_stall = valid && res_from_mem && !ready_go.
- Flush:
  - Next cycle valid=0 and FSM=EMPTY.
  - If flushed in WAIT and data_ok is not present that cycle, set discard=1.
  - The next data_ok clears discard, and its data is dropped.
  - data_ok in the same cycle as flush is consumed; discard stays 0.
- Simultaneous data_ok, discard=1, and a new instruction in WAIT: the discard is consumed first, and the new instruction keeps waiting.
- me_mem_busy = (valid && state==WAIT) || discard.
- Reset mid-WAIT clears discard. The memory side is reset together with the core, so no late response arrives.

Test Plan:
1. ALU op, alu_result=0x1234, gr_we=1, dest=5, wb_allow_in=1 -> me_to_wb_valid 1 cycle after entry, me_final_result=0x1234, me_fwd_dest=5.
2. ld.w, data_ok 3 cycles after entry with rdata=0xDEADBEEF -> me_fwd_stall=1 for 3 cycles, then result 0xDEADBEEF with valid on the data_ok cycle.
3. ld.b addr offset 3 and ld.bu offset 3, rdata=0x80112233 -> 0xFFFFFF80 and 0x00000080; ld.h offset 2 -> 0xFFFF8011; DATA_W=64 ld.w offset 4 sign -> upper word sign-extended.
4. Load, data_ok=0x55 while wb_allow_in=0 for 4 cycles -> state READY; output held at 0x55; me_allow_in=0 until WB accepts.
5. Flush in WAIT, data_ok 2 cycles later with 0xAA, then a new ld.w whose data_ok brings 0xBB -> 0xAA never reaches WB; only 0xBB is delivered.
6. resetn=0 during WAIT with discard=1 -> next cycle valid=0, discard=0, me_allow_in=1, me_mem_busy=0.
